// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, load funct3 encodings, writeback FSM states.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/rf_writeback_if.sv
// Writeback bus: ALU result handshake, load issue/response, register-file write port, status.
interface rf_writeback_if #(
  parameter int unsigned XLEN   = cpu_pkg::XLEN,
  parameter int unsigned REG_AW = cpu_pkg::REG_AW
);

  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_result;
  logic              ld_issue_valid;
  logic              ld_issue_ready;
  logic [REG_AW-1:0] ld_issue_rd;
  logic [2:0]        ld_funct3;
  logic [1:0]        ld_addr_lo;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;
  logic              rd_we;
  logic [REG_AW-1:0] rd_addr;
  logic [XLEN-1:0]   rd_wdata;
  logic              pending_valid;
  logic [REG_AW-1:0] pending_rd;
  logic              spurious_rsp;

  modport master (
    output alu_valid, alu_rd, alu_result,
    output ld_issue_valid, ld_issue_rd, ld_funct3, ld_addr_lo,
    output mem_rvalid, mem_rdata,
    input  alu_ready, ld_issue_ready,
    input  rd_we, rd_addr, rd_wdata,
    input  pending_valid, pending_rd, spurious_rsp
  );

  modport slave (
    input  alu_valid, alu_rd, alu_result,
    input  ld_issue_valid, ld_issue_rd, ld_funct3, ld_addr_lo,
    input  mem_rvalid, mem_rdata,
    output alu_ready, ld_issue_ready,
    output rd_we, rd_addr, rd_wdata,
    output pending_valid, pending_rd, spurious_rsp
  );

endinterface

// File: rtl/load_align.sv
// Load lane extraction with sign/zero extension; unknown funct3 passes the raw word.
module load_align #(
  parameter int unsigned XLEN = cpu_pkg::XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] raw_word,
  output logic [XLEN-1:0] result
);
  import cpu_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane, then extend according to the load type.
  always_comb begin
    byte_sel = raw_word[7:0];
    half_sel = raw_word[15:0];
    result   = raw_word;
    case (addr_lo)
      2'd0:    byte_sel = raw_word[7:0];
      2'd1:    byte_sel = raw_word[15:8];
      2'd2:    byte_sel = raw_word[23:16];
      default: byte_sel = raw_word[31:24];
    endcase
    half_sel = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   result = raw_word;
      default: result = raw_word;
    endcase
  end

endmodule

// File: rtl/rf_writeback.sv
// Register-file writeback: merges ALU results with one outstanding load, load has write priority.
module rf_writeback #(
  parameter int unsigned XLEN   = cpu_pkg::XLEN,
  parameter int unsigned REG_AW = cpu_pkg::REG_AW
) (
  input logic           clk,
  input logic           rst,
  rf_writeback_if.slave bus
);
  import cpu_pkg::*;

  wb_state_e         state_q, state_d;
  logic [REG_AW-1:0] pend_rd_q;
  logic [2:0]        pend_f3_q;
  logic [1:0]        pend_lo_q;
  logic              rsp_hit;
  logic              waw_block;
  logic              issue_fire;
  logic              alu_fire;
  logic              ld_ready;
  logic              alu_ready;
  logic [XLEN-1:0]   ld_data;
  logic              we_q;
  logic [REG_AW-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              spur_q;

  load_align #(.XLEN(XLEN)) u_align (
    .funct3   (pend_f3_q),
    .addr_lo  (pend_lo_q),
    .raw_word (bus.mem_rdata),
    .result   (ld_data)
  );

  // Handshake readiness and next state; a response frees the slot for a same-cycle reissue.
  always_comb begin
    state_d    = state_q;
    rsp_hit    = (state_q == WAIT_LOAD) && bus.mem_rvalid;
    waw_block  = (state_q == WAIT_LOAD) && (bus.alu_rd == pend_rd_q) && (bus.alu_rd != '0);
    ld_ready   = !rst && ((state_q == IDLE) || bus.mem_rvalid);
    alu_ready  = !rst && !rsp_hit && !waw_block;
    issue_fire = bus.ld_issue_valid && ld_ready;
    alu_fire   = bus.alu_valid && alu_ready;
    if (issue_fire) begin
      state_d = WAIT_LOAD;
    end else if (rsp_hit) begin
      state_d = IDLE;
    end
  end

  // FSM state and the recorded fields of the outstanding load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_rd_q <= '0;
      pend_f3_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q <= state_d;
      if (issue_fire) begin
        pend_rd_q <= bus.ld_issue_rd;
        pend_f3_q <= bus.ld_funct3;
        pend_lo_q <= bus.ld_addr_lo;
      end
    end
  end

  // Registered write port; x0 targets are consumed without asserting the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (rsp_hit) begin
      we_q    <= (pend_rd_q != '0);
      addr_q  <= pend_rd_q;
      wdata_q <= ld_data;
    end else if (alu_fire) begin
      we_q    <= (bus.alu_rd != '0);
      addr_q  <= bus.alu_rd;
      wdata_q <= bus.alu_result;
    end else begin
      we_q <= 1'b0;
    end
  end

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      spur_q <= 1'b0;
    end else if (bus.mem_rvalid && (state_q == IDLE)) begin
      spur_q <= 1'b1;
    end
  end

  assign bus.alu_ready      = alu_ready;
  assign bus.ld_issue_ready = ld_ready;
  assign bus.rd_we          = we_q;
  assign bus.rd_addr        = addr_q;
  assign bus.rd_wdata       = wdata_q;
  assign bus.pending_valid  = (state_q == WAIT_LOAD);
  assign bus.pending_rd     = pend_rd_q;
  assign bus.spurious_rsp   = spur_q;

endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: directed test-plan cases plus random traffic against a behavioural model.
module tb_rf_writeback;

  logic clk = 1'b0;
  logic rst;

  rf_writeback_if #(.XLEN(32), .REG_AW(5)) bus ();

  rf_writeback #(.XLEN(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference extraction written as shift arithmetic on the word.
  function automatic logic [31:0] m_align(input logic [2:0] f3, input logic [1:0] lo,
                                          input logic [31:0] w);
    int bsh;
    int hsh;
    logic signed [31:0] s;
    bsh = 24 - 8 * int'(lo);
    hsh = 16 - 8 * int'(lo & 2'b10);
    case (f3)
      3'b000: begin s = $signed(w << bsh); return s >>> 24; end
      3'b100: return (w << bsh) >> 24;
      3'b001: begin s = $signed(w << hsh); return s >>> 16; end
      3'b101: return (w << hsh) >> 16;
      default: return w;
    endcase
  endfunction

  // Behavioural model: at most one outstanding load, expected write for the next cycle.
  logic        m_started = 1'b0;
  logic        m_out, m_spur, m_fresh, m_pfresh;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_lo;
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;

  wire m_rsp    = bus.mem_rvalid && m_out;
  wire m_lready = !rst && (!m_out || bus.mem_rvalid);
  wire m_aready = !rst && !m_rsp && !(m_out && bus.alu_rd == m_rd && bus.alu_rd != 5'd0);
  wire m_alu_acc = bus.alu_valid && m_aready;
  wire m_ld_acc  = bus.ld_issue_valid && m_lready;

  always @(posedge clk) begin
    if (rst) begin
      m_started <= 1'b1;
      m_out     <= 1'b0;
      m_spur    <= 1'b0;
      m_fresh   <= 1'b1;
      m_pfresh  <= 1'b1;
      m_rd      <= 5'd0;
      m_f3      <= 3'd0;
      m_lo      <= 2'd0;
      exp_we    <= 1'b0;
      exp_addr  <= 5'd0;
      exp_data  <= 32'd0;
    end else begin
      if (bus.mem_rvalid && !m_out) m_spur <= 1'b1;
      if (m_rsp) begin
        exp_we   <= (m_rd != 5'd0);
        exp_addr <= m_rd;
        exp_data <= m_align(m_f3, m_lo, bus.mem_rdata);
        m_fresh  <= 1'b0;
      end else if (m_alu_acc) begin
        exp_we   <= (bus.alu_rd != 5'd0);
        exp_addr <= bus.alu_rd;
        exp_data <= bus.alu_result;
        m_fresh  <= 1'b0;
      end else begin
        exp_we <= 1'b0;
      end
      if (m_ld_acc) begin
        m_out    <= 1'b1;
        m_rd     <= bus.ld_issue_rd;
        m_f3     <= bus.ld_funct3;
        m_lo     <= bus.ld_addr_lo;
        m_pfresh <= 1'b0;
      end else if (m_rsp) begin
        m_out <= 1'b0;
      end
    end
  end

  // Compare process: every negedge once reset has been seen.
  always @(negedge clk) begin
    if (m_started) begin
      chk("rd_we", {31'd0, bus.rd_we}, {31'd0, exp_we});
      if (exp_we || m_fresh) begin
        chk("rd_addr", {27'd0, bus.rd_addr}, {27'd0, exp_addr});
        chk("rd_wdata", bus.rd_wdata, exp_data);
      end
      chk("pending_valid", {31'd0, bus.pending_valid}, {31'd0, m_out});
      if (m_out || m_pfresh) chk("pending_rd", {27'd0, bus.pending_rd}, {27'd0, m_rd});
      chk("spurious_rsp", {31'd0, bus.spurious_rsp}, {31'd0, m_spur});
      chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, m_aready});
      chk("ld_issue_ready", {31'd0, bus.ld_issue_ready}, {31'd0, m_lready});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.alu_valid      = 1'b0;
    bus.alu_rd         = 5'd0;
    bus.alu_result     = 32'd0;
    bus.ld_issue_valid = 1'b0;
    bus.ld_issue_rd    = 5'd0;
    bus.ld_funct3      = 3'd0;
    bus.ld_addr_lo     = 2'd0;
    bus.mem_rvalid     = 1'b0;
    bus.mem_rdata      = 32'd0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
    bus.ld_issue_valid = 1'b1;
    bus.ld_issue_rd    = rd;
    bus.ld_funct3      = f3;
    bus.ld_addr_lo     = lo;
    step();
    clr();
  endtask

  task automatic load_chk(input string name, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] lo, input logic [31:0] data, input logic [31:0] exp);
    issue(rd, f3, lo);
    chk({name, "_pv"}, {31'd0, bus.pending_valid}, 32'd1);
    chk({name, "_prd"}, {27'd0, bus.pending_rd}, {27'd0, rd});
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = data;
    step();
    clr();
    chk({name, "_we"}, {31'd0, bus.rd_we}, 32'd1);
    chk({name, "_addr"}, {27'd0, bus.rd_addr}, {27'd0, rd});
    chk({name, "_data"}, bus.rd_wdata, exp);
  endtask

  initial begin
    clr();
    rst = 1'b1;
    step();
    step();
    chk("rst_we", {31'd0, bus.rd_we}, 32'd0);
    chk("rst_addr", {27'd0, bus.rd_addr}, 32'd0);
    chk("rst_wdata", bus.rd_wdata, 32'd0);
    chk("rst_pv", {31'd0, bus.pending_valid}, 32'd0);
    chk("rst_aready", {31'd0, bus.alu_ready}, 32'd0);
    chk("rst_lready", {31'd0, bus.ld_issue_ready}, 32'd0);
    rst = 1'b0;

    // Plain ALU write and its one-cycle enable.
    bus.alu_valid  = 1'b1;
    bus.alu_rd     = 5'd5;
    bus.alu_result = 32'hDEADBEEF;
    step();
    clr();
    chk("alu_we", {31'd0, bus.rd_we}, 32'd1);
    chk("alu_addr", {27'd0, bus.rd_addr}, 32'd5);
    chk("alu_data", bus.rd_wdata, 32'hDEADBEEF);
    step();
    chk("alu_we_drop", {31'd0, bus.rd_we}, 32'd0);

    // Load extraction cases.
    load_chk("lb",  5'd7, 3'b000, 2'd2, 32'h12853456, 32'hFFFFFF85);
    load_chk("lbu", 5'd7, 3'b100, 2'd2, 32'h12853456, 32'h00000085);
    load_chk("lh",  5'd7, 3'b001, 2'd2, 32'h12853456, 32'h00001285);
    load_chk("lhu", 5'd7, 3'b101, 2'd0, 32'h00009ABC, 32'h00009ABC);
    load_chk("lh_neg", 5'd8, 3'b001, 2'd1, 32'h00008001, 32'hFFFF8001);

    // WAW hold on matching destination.
    issue(5'd3, 3'b010, 2'd0);
    bus.alu_valid  = 1'b1;
    bus.alu_rd     = 5'd3;
    bus.alu_result = 32'h00003333;
    #1;
    chk("waw_block", {31'd0, bus.alu_ready}, 32'd0);
    step();
    chk("waw_hold", {31'd0, bus.alu_ready}, 32'd0);
    chk("waw_nowrite", {31'd0, bus.rd_we}, 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hAAAA5555;
    #1;
    chk("rsp_block", {31'd0, bus.alu_ready}, 32'd0);
    step();
    bus.mem_rvalid = 1'b0;
    chk("waw_ld_addr", {27'd0, bus.rd_addr}, 32'd3);
    chk("waw_ld_data", bus.rd_wdata, 32'hAAAA5555);
    #1;
    chk("waw_release", {31'd0, bus.alu_ready}, 32'd1);
    step();
    clr();
    chk("waw_alu_we", {31'd0, bus.rd_we}, 32'd1);
    chk("waw_alu_data", bus.rd_wdata, 32'h00003333);

    // Different destination proceeds while the load is pending.
    issue(5'd3, 3'b010, 2'd0);
    bus.alu_valid  = 1'b1;
    bus.alu_rd     = 5'd4;
    bus.alu_result = 32'h00004444;
    #1;
    chk("other_rd_ready", {31'd0, bus.alu_ready}, 32'd1);
    step();
    clr();
    chk("other_rd_addr", {27'd0, bus.rd_addr}, 32'd4);
    bus.mem_rvalid = 1'b1;
    step();
    clr();

    // Response, ALU offer and reissue in the same cycle.
    issue(5'd9, 3'b010, 2'd0);
    bus.mem_rvalid     = 1'b1;
    bus.mem_rdata      = 32'h00000099;
    bus.alu_valid      = 1'b1;
    bus.alu_rd         = 5'd10;
    bus.alu_result     = 32'h00001010;
    bus.ld_issue_valid = 1'b1;
    bus.ld_issue_rd    = 5'd11;
    bus.ld_funct3      = 3'b010;
    #1;
    chk("sim_lready", {31'd0, bus.ld_issue_ready}, 32'd1);
    chk("sim_aready", {31'd0, bus.alu_ready}, 32'd0);
    step();
    bus.mem_rvalid     = 1'b0;
    bus.ld_issue_valid = 1'b0;
    chk("sim_ld_addr", {27'd0, bus.rd_addr}, 32'd9);
    chk("sim_ld_data", bus.rd_wdata, 32'h00000099);
    chk("sim_pv", {31'd0, bus.pending_valid}, 32'd1);
    chk("sim_prd", {27'd0, bus.pending_rd}, 32'd11);
    step();
    clr();
    chk("sim_alu_we", {31'd0, bus.rd_we}, 32'd1);
    chk("sim_alu_addr", {27'd0, bus.rd_addr}, 32'd10);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h00000011;
    step();
    clr();
    chk("sim_ld2_addr", {27'd0, bus.rd_addr}, 32'd11);

    // Load to x0 and a spurious response.
    issue(5'd0, 3'b010, 2'd0);
    chk("x0_pv", {31'd0, bus.pending_valid}, 32'd1);
    bus.mem_rvalid = 1'b1;
    step();
    clr();
    chk("x0_we", {31'd0, bus.rd_we}, 32'd0);
    chk("x0_pv_drop", {31'd0, bus.pending_valid}, 32'd0);
    chk("spur_pre", {31'd0, bus.spurious_rsp}, 32'd0);
    bus.mem_rvalid = 1'b1;
    step();
    clr();
    chk("spur_set", {31'd0, bus.spurious_rsp}, 32'd1);
    chk("spur_nowrite", {31'd0, bus.rd_we}, 32'd0);

    // Reset in the middle of a load.
    issue(5'd6, 3'b010, 2'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_pv", {31'd0, bus.pending_valid}, 32'd0);
    chk("mid_rst_prd", {27'd0, bus.pending_rd}, 32'd0);
    chk("mid_rst_spur", {31'd0, bus.spurious_rsp}, 32'd0);
    chk("mid_rst_addr", {27'd0, bus.rd_addr}, 32'd0);
    chk("mid_rst_wdata", bus.rd_wdata, 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h00000066;
    step();
    clr();
    chk("late_rsp_spur", {31'd0, bus.spurious_rsp}, 32'd1);
    chk("late_rsp_we", {31'd0, bus.rd_we}, 32'd0);

    // Random traffic; small register range to provoke hazards.
    for (int i = 0; i < 4000; i++) begin
      rst                = ($urandom_range(0, 299) == 0);
      bus.alu_valid      = 1'($urandom_range(0, 1));
      bus.alu_rd         = 5'($urandom_range(0, 7));
      bus.alu_result     = $urandom;
      bus.ld_issue_valid = ($urandom_range(0, 2) == 0);
      bus.ld_issue_rd    = 5'($urandom_range(0, 7));
      bus.ld_funct3      = 3'($urandom_range(0, 7));
      bus.ld_addr_lo     = 2'($urandom_range(0, 3));
      bus.mem_rvalid     = ($urandom_range(0, 2) == 0);
      bus.mem_rdata      = $urandom;
      step();
    end
    clr();
    rst = 1'b0;
    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rf_writeback.md
# rf_writeback

Writeback stage that owns the write port of the 32x32 integer register file. It merges ALU results with one outstanding memory load and performs byte/halfword extraction with sign or zero extension. It enforces write ordering between a pending load and younger ALU results, and drives registered `rd_we`/`rd_addr`/`rd_wdata` straight into the register file.

## Interface
Parameters:
- XLEN, 32, data width
- REG_AW, 5, register address width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; **synchronous, active-high**
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle when alu_valid & alu_ready
- alu_rd  in  REG_AW  destination register of ALU result
- alu_result  in  XLEN  ALU result
- ld_issue_valid  in  1  load issued to memory
- ld_issue_ready  out  1  load issue accepted when ld_issue_valid & ld_issue_ready
- ld_issue_rd  in  REG_AW  load destination register
- ld_funct3  in  3  load type (LB 000, LH 001, LW 010, LBU 100, LHU 101)
- ld_addr_lo  in  2  low address bits of the load
- mem_rvalid  in  1  load response valid (single cycle)
- mem_rdata  in  XLEN  raw aligned word from memory
- rd_we  out  1  register file write enable (registered)
- rd_addr  out  REG_AW  register file write address (registered)
- rd_wdata  out  XLEN  register file write data (registered)
- pending_valid  out  1  a load is outstanding
- pending_rd  out  REG_AW  destination of the outstanding load
- spurious_rsp  out  1  sticky; set by mem_rvalid while no load is outstanding

## Operation
- States: IDLE (no load outstanding) and WAIT_LOAD (one load outstanding). Recorded fields: rd, funct3, addr_lo.
- IDLE -> WAIT_LOAD on an accepted load issue.
- WAIT_LOAD -> IDLE on mem_rvalid, unless a new issue is accepted in the same cycle. In that case the state stays WAIT_LOAD with the new fields loaded.
- ld_issue_ready = (state==IDLE) | mem_rvalid. This allows back-to-back loads.
- Write arbitration: a load response has priority. When mem_rvalid=1 in WAIT_LOAD, alu_ready=0.
- WAW ordering: in WAIT_LOAD, alu_ready=0 when alu_rd==pending_rd and alu_rd!=0. A younger ALU write must not be overwritten by an older load.
- Otherwise alu_ready=1. The block has no ALU buffering and never drops an accepted result.
- Load alignment:
  - Byte lane = addr_lo. Halfword lane = addr_lo[1]; addr_lo[0] is ignored for LH/LHU.
  - LW ignores addr_lo.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Unlisted funct3 (011, 110, 111) write the raw word.
- rd==0: the transaction is accepted and a load still occupies WAIT_LOAD, but rd_we stays 0.
- mem_rvalid in IDLE: ignored for writing and sets spurious_rsp. Only rst clears spurious_rsp.

## Timing
- Reset values: rd_we=0, rd_addr=0, rd_wdata=0, pending_valid=0, pending_rd=0, spurious_rsp=0, state=IDLE.
- While rst=1: alu_ready=0 and ld_issue_ready=0.
- Latency: an ALU accept or mem_rvalid in cycle N gives rd_we=1 in cycle N+1 with final address and data.
- rd_we is 0 in any cycle following no write.
- pending_valid/pending_rd are registered. They assert the cycle after the issue is accepted and deassert the cycle after mem_rvalid, unless a same-cycle reissue occurs.
- Reset mid-load: the outstanding load is discarded. A later response is spurious and produces no write.
- Simultaneous ALU offer and load response: the load writes in N+1; the ALU is accepted no earlier than N+1 and writes in N+2.

## Structure
- Shared package `cpu_pkg`: XLEN and REG_AW constants, load funct3 encodings, wb_state enum {IDLE, WAIT_LOAD}.
- Sub-module `load_align`: combinational; inputs funct3, addr_lo, raw word; output extended XLEN result. Shared with future store/load units.

## Test plan
- ALU result rd=5, data 0xDEADBEEF, no loads -> next cycle rd_we=1, rd_addr=5, rd_wdata=0xDEADBEEF; following cycle rd_we=0.
- Load LB rd=7, addr_lo=2; response 0x12_85_34_56 -> rd_wdata=0xFFFFFF85. Repeat with LBU -> 0x00000085; LH with addr_lo=2 -> 0x00001285; LHU with addr_lo=0, data 0x0000_9ABC -> 0x00009ABC.
- Load rd=3 pending, ALU offers rd=3 -> alu_ready=0 until the response. Load writes first, ALU writes the next cycle. ALU offering rd=4 is accepted immediately.
- mem_rvalid and alu_valid in the same cycle -> load writes in N+1, ALU in N+2. A load issue in the response cycle is accepted and pending_valid stays 1.
- Load to rd=0 -> pending_valid=1, the response gives rd_we=0. mem_rvalid in IDLE -> spurious_rsp=1 and no write.
- rst asserted in WAIT_LOAD -> next cycle all outputs at reset values. The subsequent mem_rvalid sets spurious_rsp and produces no write.
